// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: password-qualified entry, occupancy tracking,
// lockout after repeated wrong codes and a tailgate stop state.
module parking_gate_ctrl #(
    parameter int unsigned           SLOTS       = 8,
    parameter int unsigned           PW_W        = 4,
    parameter logic [PW_W-1:0]       PASSWORD    = PW_W'(13),
    parameter int unsigned           PW_TIMEOUT  = 16,
    parameter int unsigned           MAX_TRIES   = 3,
    parameter int unsigned           LOCK_CYCLES = 32,
    parameter int unsigned           GATE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sensor_entry,
    input  logic                         sensor_exit,
    input  logic                         pw_valid,
    input  logic [PW_W-1:0]              password,
    output logic                         gate_open,
    output logic [$clog2(SLOTS+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         alarm,
    output logic                         green_led,
    output logic                         red_led,
    output logic                         yellow_led,
    output logic                         blue_led
);

    localparam int unsigned OW    = $clog2(SLOTS + 1);
    localparam int unsigned TMAX0 = (PW_TIMEOUT > LOCK_CYCLES) ? PW_TIMEOUT : LOCK_CYCLES;
    localparam int unsigned TMAX  = (TMAX0 > GATE_CYCLES) ? TMAX0 : GATE_CYCLES;
    localparam int unsigned TW    = $clog2(TMAX + 1);
    localparam int unsigned TRW   = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PW,
        GRANTED,
        LOCKOUT,
        SYS_STOP
    } state_t;

    state_t          state, state_next;
    logic            entry_q, exit_q;
    logic [TRW-1:0]  tries, tries_next, tries_inc;
    logic [TW-1:0]   timer, timer_next;
    logic [OW-1:0]   occ_next;
    logic            entry_edge, exit_edge, pw_ok;
    logic            inc, dec, full_reject;
    logic            gate_n, full_n, alarm_n, green_n, red_n, yellow_n, blue_n;

    assign entry_edge = sensor_entry & ~entry_q;
    assign exit_edge  = sensor_exit & ~exit_q;
    assign pw_ok      = pw_valid && (password == PASSWORD);
    assign tries_inc  = tries + TRW'(1);

    always_comb begin
        state_next  = state;
        tries_next  = tries;
        timer_next  = timer;
        inc         = 1'b0;
        full_reject = 1'b0;
        case (state)
            IDLE: begin
                if (entry_edge) begin
                    if (full) begin
                        full_reject = 1'b1;
                    end else begin
                        state_next = WAIT_PW;
                        tries_next = '0;
                        timer_next = '0;
                    end
                end
            end
            WAIT_PW: begin
                if (pw_valid) begin
                    timer_next = '0;
                    if (pw_ok) begin
                        state_next = GRANTED;
                        tries_next = '0;
                    end else begin
                        tries_next = tries_inc;
                        if (tries_inc == TRW'(MAX_TRIES)) begin
                            state_next = LOCKOUT;
                        end
                    end
                end else if (timer == TW'(PW_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GRANTED: begin
                // Tailgate takes priority even on the final gate cycle.
                if (sensor_entry && sensor_exit) begin
                    state_next = SYS_STOP;
                    timer_next = '0;
                end else if (timer == TW'(GATE_CYCLES - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    inc        = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            LOCKOUT: begin
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    state_next = IDLE;
                    tries_next = '0;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            SYS_STOP: begin
                if (pw_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tries_next = '0;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        dec      = exit_edge && (occupancy != '0);
        occ_next = occupancy;
        if (inc && !dec) begin
            occ_next = occupancy + OW'(1);
        end else if (dec && !inc) begin
            occ_next = occupancy - OW'(1);
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state.
    always_comb begin
        full_n   = (occ_next == OW'(SLOTS));
        gate_n   = (state_next == GRANTED);
        alarm_n  = (state_next == LOCKOUT) || (state_next == SYS_STOP);
        green_n  = (state_next == GRANTED);
        yellow_n = (state_next == WAIT_PW) || (state_next == SYS_STOP);
        blue_n   = (state_next == IDLE) || (state_next == WAIT_PW);
        red_n    = (state_next == SYS_STOP) || full_reject ||
                   ((state_next == LOCKOUT) && !timer_next[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tries      <= '0;
            timer      <= '0;
            entry_q    <= 1'b0;
            exit_q     <= 1'b0;
            occupancy  <= '0;
            full       <= 1'b0;
            gate_open  <= 1'b0;
            alarm      <= 1'b0;
            green_led  <= 1'b0;
            red_led    <= 1'b0;
            yellow_led <= 1'b0;
            blue_led   <= 1'b1;
        end else begin
            state      <= state_next;
            tries      <= tries_next;
            timer      <= timer_next;
            entry_q    <= sensor_entry;
            exit_q     <= sensor_exit;
            occupancy  <= occ_next;
            full       <= full_n;
            gate_open  <= gate_n;
            alarm      <= alarm_n;
            green_led  <= green_n;
            red_led    <= red_n;
            yellow_led <= yellow_n;
            blue_led   <= blue_n;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios then random traffic, all
// outputs compared every cycle against a countdown-based reference model.
module tb_parking_gate_ctrl;

    localparam int SLOTS  = 8;
    localparam int PW_W   = 4;
    localparam int PASS   = 13;
    localparam int PW_TO  = 16;
    localparam int TRIES  = 3;
    localparam int LOCK   = 32;
    localparam int GATE   = 8;
    localparam int OW     = $clog2(SLOTS + 1);

    localparam int M_IDLE = 0, M_WAIT = 1, M_GRANT = 2, M_LOCK = 3, M_STOP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            se = 1'b0, sx = 1'b0, pv = 1'b0;
    logic [PW_W-1:0] pw = '0;
    logic            gate_open, full, alarm, green_led, red_led, yellow_led, blue_led;
    logic [OW-1:0]   occupancy;

    int errors = 0;
    int checks = 0;

    // reference model
    int m_mode, m_occ, m_wrong, m_pw_left, m_gate_left, m_lock_left;
    bit m_lock_red, m_red_pulse, m_prev_se, m_prev_sx;

    parking_gate_ctrl #(
        .SLOTS(SLOTS), .PW_W(PW_W), .PASSWORD(4'd13), .PW_TIMEOUT(PW_TO),
        .MAX_TRIES(TRIES), .LOCK_CYCLES(LOCK), .GATE_CYCLES(GATE)
    ) dut (
        .clk(clk), .rst(rst), .sensor_entry(se), .sensor_exit(sx),
        .pw_valid(pv), .password(pw), .gate_open(gate_open), .occupancy(occupancy),
        .full(full), .alarm(alarm), .green_led(green_led), .red_led(red_led),
        .yellow_led(yellow_led), .blue_led(blue_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_occ = 0; m_wrong = 0; m_pw_left = 0;
        m_gate_left = 0; m_lock_left = 0; m_lock_red = 0; m_red_pulse = 0;
        m_prev_se = 0; m_prev_sx = 0;
    endtask

    task automatic model_step();
        bit e_edge, x_edge;
        int inc, dec;
        e_edge = se && !m_prev_se;
        x_edge = sx && !m_prev_sx;
        inc = 0;
        m_red_pulse = 0;
        case (m_mode)
            M_IDLE: if (e_edge) begin
                if (m_occ == SLOTS) m_red_pulse = 1;
                else begin m_mode = M_WAIT; m_wrong = 0; m_pw_left = PW_TO; end
            end
            M_WAIT: if (pv) begin
                if (int'(pw) == PASS) begin m_mode = M_GRANT; m_gate_left = GATE; end
                else begin
                    m_wrong++;
                    m_pw_left = PW_TO;
                    if (m_wrong == TRIES) begin m_mode = M_LOCK; m_lock_left = LOCK; m_lock_red = 1; end
                end
            end else begin
                m_pw_left--;
                if (m_pw_left == 0) m_mode = M_IDLE;
            end
            M_GRANT: if (se && sx) m_mode = M_STOP;
            else begin
                m_gate_left--;
                if (m_gate_left == 0) begin inc = 1; m_mode = M_IDLE; end
            end
            M_LOCK: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_mode = M_IDLE; m_wrong = 0; end
                else m_lock_red = !m_lock_red;
            end
            M_STOP: if (pv && int'(pw) == PASS) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        dec = (x_edge && m_occ > 0) ? 1 : 0;
        m_occ = m_occ + inc - dec;
        m_prev_se = se;
        m_prev_sx = sx;
    endtask

    task automatic check_all();
        chk("gate_open",  32'(gate_open),  32'(m_mode == M_GRANT));
        chk("occupancy",  32'(occupancy),  32'(m_occ));
        chk("full",       32'(full),       32'(m_occ == SLOTS));
        chk("alarm",      32'(alarm),      32'(m_mode == M_LOCK || m_mode == M_STOP));
        chk("green_led",  32'(green_led),  32'(m_mode == M_GRANT));
        chk("yellow_led", 32'(yellow_led), 32'(m_mode == M_WAIT || m_mode == M_STOP));
        chk("blue_led",   32'(blue_led),   32'(m_mode == M_IDLE || m_mode == M_WAIT));
        chk("red_led",    32'(red_led),
            32'(m_red_pulse || m_mode == M_STOP || (m_mode == M_LOCK && m_lock_red)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        se = 0; sx = 0; pv = 0; pw = '0;
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1;
    endtask

    task automatic admit();
        se = 1; tick();
        se = 0; pv = 1; pw = 4'd13; tick();
        pv = 0;
        repeat (GATE) tick();
    endtask

    initial begin
        int cnt_a, cnt_b, occ_before;

        // reset state
        do_reset();
        chk("reset_blue", 32'(blue_led), 32'd1);
        chk("reset_occ", 32'(occupancy), 32'd0);

        // correct code admits one vehicle
        se = 1; tick();
        se = 0; pv = 1; pw = 4'd13; tick();
        pv = 0;
        cnt_a = int'(gate_open);
        repeat (12) begin tick(); cnt_a += int'(gate_open); end
        chk("gate_cycles", 32'(cnt_a), 32'd8);
        chk("occ_after_admit", 32'(occupancy), 32'd1);
        chk("idle_blue", 32'(blue_led), 32'd1);

        // three wrong codes lock out; correct code inside lockout is ignored
        se = 1; tick();
        se = 0; pv = 1; pw = 4'd0;
        repeat (3) tick();
        pv = 0;
        cnt_a = int'(alarm);
        cnt_b = int'(alarm && red_led);
        for (int i = 0; i < 40; i++) begin
            pv = (i == 5); pw = 4'd13;
            tick();
            cnt_a += int'(alarm);
            cnt_b += int'(alarm && red_led);
        end
        pv = 0;
        chk("lock_cycles", 32'(cnt_a), 32'd32);
        chk("lock_red_highs", 32'(cnt_b), 32'd16);
        chk("after_lock_blue", 32'(blue_led), 32'd1);

        // fill the lot, refused entry, one exit frees a slot
        repeat (7) admit();
        chk("full_at_8", 32'(full), 32'd1);
        chk("occ_at_8", 32'(occupancy), 32'd8);
        se = 1; tick();
        chk("refused_red", 32'(red_led), 32'd1);
        chk("refused_idle", 32'(yellow_led), 32'd0);
        se = 0; tick();
        chk("refused_red_clear", 32'(red_led), 32'd0);
        sx = 1; tick();
        sx = 0; tick();
        chk("occ_after_exit", 32'(occupancy), 32'd7);
        chk("not_full", 32'(full), 32'd0);

        // tailgate: exit sensor already high, entry rises during GRANTED
        se = 1; tick();
        se = 0; sx = 1; tick();
        pv = 1; pw = 4'd13; tick();
        pv = 0; tick(); tick();
        occ_before = int'(occupancy);
        se = 1; tick();
        chk("stop_red", 32'(red_led), 32'd1);
        chk("stop_yellow", 32'(yellow_led), 32'd1);
        chk("stop_alarm", 32'(alarm), 32'd1);
        chk("stop_gate", 32'(gate_open), 32'd0);
        chk("stop_occ", 32'(occupancy), 32'(occ_before));
        se = 0; sx = 0; tick();
        pv = 1; pw = 4'd6; tick();
        chk("stop_wrong_ignored", 32'(alarm), 32'd1);
        pw = 4'd13; tick();
        pv = 0;
        chk("stop_exit_blue", 32'(blue_led), 32'd1);

        // exit at empty lot, simultaneous increment/decrement
        do_reset();
        sx = 1; tick();
        sx = 0; tick();
        chk("no_underflow", 32'(occupancy), 32'd0);
        repeat (3) admit();
        se = 1; tick();
        se = 0; pv = 1; pw = 4'd13; tick();
        pv = 0;
        repeat (GATE - 1) tick();
        sx = 1; tick();
        sx = 0; tick();
        chk("inc_dec_same_cycle", 32'(occupancy), 32'd3);

        // password timeout
        se = 1; tick();
        se = 0;
        cnt_a = int'(yellow_led);
        repeat (20) begin tick(); cnt_a += int'(yellow_led); end
        chk("timeout_wait_cycles", 32'(cnt_a), 32'd16);

        // asynchronous reset in the middle of GRANTED
        se = 1; tick();
        se = 0; pv = 1; pw = 4'd13; tick();
        pv = 0; tick(); tick();
        rst = 0;
        #1;
        chk("async_gate", 32'(gate_open), 32'd0);
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_blue", 32'(blue_led), 32'd1);
        chk("async_green", 32'(green_led), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            se = ($urandom_range(0, 3) == 0);
            sx = ($urandom_range(0, 9) == 0);
            pv = ($urandom_range(0, 3) == 0);
            pw = ($urandom_range(0, 1) == 1) ? 4'd13 : 4'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not complete");
    end

endmodule
